ppu_vram_ctrl: RTL and testbench

PPU-side VRAM responder: services the background fetcher's VRAM read port and the CPU's PPUADDR/PPUDATA ($2006/$2007) access path against one PPU address space. Holds 2 KB nametable RAM and 32-entry palette RAM internally and reaches 8 KB CHR ROM through an external asynchronous port. Applies nametable mirroring, defers CPU accesses while rendering owns the bus, and implements the PPUDATA read buffer.

---
 rtl/ppu_vram_ctrl.sv | 146 ++++++++++++++
 tb/tb_ppu_vram_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_ctrl.sv
// PPU-side VRAM responder: fetcher read port plus CPU PPUADDR/PPUDATA path,
// with nametable mirroring, 32-entry palette, external CHR ROM and read buffer.
module ppu_vram_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] VRAM_addr,
  output logic [7:0]  VRAM_data_out,
  input  logic        render_active,
  input  logic        mirror_vert,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_data,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic        addr_latch_clr,
  input  logic        addr_inc32,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy
);

  logic [7:0]  nt_mem  [2048];
  logic [5:0]  pal_mem [32];

  logic [13:0] v_reg;
  logic [5:0]  t_hi_reg;
  logic        w_reg;
  logic [7:0]  rbuf_reg;
  logic        pend_valid_reg;
  logic        pend_wr_reg;
  logic [7:0]  pend_data_reg;

  logic [13:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        unused_addr_bits;

  logic        issue;
  logic        commit;
  logic        commit_wr;
  logic [7:0]  commit_data;
  logic        capture;
  logic        v_is_pal;
  logic        v_is_nt;
  logic [7:0]  v_rd_data;
  logic        nt_we;
  logic [13:0] v_inc;

  function automatic logic [10:0] nt_index(input logic [13:0] a, input logic mv);
    return mv ? {a[10], a[9:0]} : {a[11], a[9:0]};
  endfunction

  // Sprite-palette backdrop entries (x0 of 0x3F10/14/18/1C) share the BG slots.
  function automatic logic [4:0] pal_index(input logic [13:0] a);
    logic [4:0] idx;
    idx = a[4:0];
    if (idx[4] && (idx[1:0] == 2'b00)) idx[4] = 1'b0;
    return idx;
  endfunction

  assign fetch_addr       = VRAM_addr[13:0];
  assign unused_addr_bits = ^VRAM_addr[15:14];

  always_comb begin
    fetch_data = 8'h00;
    if (render_active) begin
      if (!fetch_addr[13])
        fetch_data = chr_data;
      else if (fetch_addr[13:8] == 6'h3F)
        fetch_data = {2'b00, pal_mem[pal_index(fetch_addr)]};
      else
        fetch_data = nt_mem[nt_index(fetch_addr, mirror_vert)];
    end
  end

  assign VRAM_data_out = fetch_data;
  assign chr_addr      = render_active ? VRAM_addr[12:0] : v_reg[12:0];

  // A held op always commits ahead of a new strobe; the new one takes its slot.
  assign issue       = cpu_data_wr | cpu_data_rd;
  assign commit      = !render_active && (pend_valid_reg || issue);
  assign commit_wr   = pend_valid_reg ? pend_wr_reg   : cpu_data_wr;
  assign commit_data = pend_valid_reg ? pend_data_reg : cpu_din;
  assign capture     = issue && (pend_valid_reg ? !render_active : render_active);

  assign v_is_pal  = (v_reg[13:8] == 6'h3F);
  assign v_is_nt   = v_reg[13] && !v_is_pal;
  // Palette-region reads still fill the buffer from the nametable underneath.
  assign v_rd_data = v_reg[13] ? nt_mem[nt_index(v_reg, mirror_vert)] : chr_data;
  assign nt_we     = commit && commit_wr && v_is_nt && reset_n;
  assign v_inc     = v_reg + (addr_inc32 ? 14'd32 : 14'd1);

  always_ff @(posedge clk) begin
    if (nt_we)
      nt_mem[nt_index(v_reg, mirror_vert)] <= commit_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_reg          <= '0;
      t_hi_reg       <= '0;
      w_reg          <= 1'b0;
      rbuf_reg       <= '0;
      pend_valid_reg <= 1'b0;
      pend_wr_reg    <= 1'b0;
      pend_data_reg  <= '0;
      cpu_dout       <= '0;
      for (int i = 0; i < 32; i++)
        pal_mem[i] <= '0;
    end else begin
      if (commit) begin
        v_reg <= v_inc;
        if (commit_wr) begin
          if (v_is_pal)
            pal_mem[pal_index(v_reg)] <= commit_data[5:0];
        end else begin
          cpu_dout <= v_is_pal ? {2'b00, pal_mem[pal_index(v_reg)]} : rbuf_reg;
          rbuf_reg <= v_rd_data;
        end
      end

      // An address load overrides a same-cycle commit increment.
      if (cpu_addr_wr) begin
        if (!w_reg || addr_latch_clr) begin
          t_hi_reg <= cpu_din[5:0];
          w_reg    <= 1'b1;
        end else begin
          v_reg <= {t_hi_reg, cpu_din};
          w_reg <= 1'b0;
        end
      end else if (addr_latch_clr) begin
        w_reg <= 1'b0;
      end

      if (capture) begin
        pend_valid_reg <= 1'b1;
        pend_wr_reg    <= cpu_data_wr;
        pend_data_reg  <= cpu_din;
      end else if (commit) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign cpu_busy = pend_valid_reg;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Self-checking bench for ppu_vram_ctrl: PPUDATA read results go through an
// expectation queue; fetch port, address and busy are checked directly.
module tb_ppu_vram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] VRAM_addr;
  logic [7:0]  VRAM_data_out;
  logic        render_active;
  logic        mirror_vert;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data;
  logic [7:0]  cpu_din;
  logic        cpu_addr_wr;
  logic        cpu_data_wr;
  logic        cpu_data_rd;
  logic        addr_latch_clr;
  logic        addr_inc32;
  logic [7:0]  cpu_dout;
  logic        cpu_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // CHR ROM stand-in: a fixed pattern of its address.
  assign chr_data = chr_addr[7:0] ^ 8'h5A;

  ppu_vram_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .VRAM_addr      (VRAM_addr),
    .VRAM_data_out  (VRAM_data_out),
    .render_active  (render_active),
    .mirror_vert    (mirror_vert),
    .chr_addr       (chr_addr),
    .chr_data       (chr_data),
    .cpu_din        (cpu_din),
    .cpu_addr_wr    (cpu_addr_wr),
    .cpu_data_wr    (cpu_data_wr),
    .cpu_data_rd    (cpu_data_rd),
    .addr_latch_clr (addr_latch_clr),
    .addr_inc32     (addr_inc32),
    .cpu_dout       (cpu_dout),
    .cpu_busy       (cpu_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected none queued", tag, cpu_dout);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {8'h00, cpu_dout}, {8'h00, e});
    end
  endtask

  task automatic addr_wr(input logic [7:0] b);
    cpu_din = b;
    cpu_addr_wr = 1'b1;
    tick();
    cpu_addr_wr = 1'b0;
  endtask

  task automatic set_v(input logic [15:0] a);
    addr_wr(a[15:8]);
    addr_wr(a[7:0]);
  endtask

  task automatic data_wr(input logic [7:0] b);
    cpu_din = b;
    cpu_data_wr = 1'b1;
    tick();
    cpu_data_wr = 1'b0;
  endtask

  task automatic data_rd(input logic [7:0] exp);
    exp_q.push_back(exp);
    cpu_data_rd = 1'b1;
    tick();
    cpu_data_rd = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    VRAM_addr = a;
    #1;
    chk(tag, {8'h00, VRAM_data_out}, {8'h00, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; VRAM_addr = '0; render_active = 1'b0; mirror_vert = 1'b0;
    cpu_din = '0; cpu_addr_wr = 1'b0; cpu_data_wr = 1'b0; cpu_data_rd = 1'b0;
    addr_latch_clr = 1'b0; addr_inc32 = 1'b0;
    #22;
    reset_n = 1'b1;
    tick();
    chk("reset_dout", {8'h00, cpu_dout}, 16'h0000);
    chk("reset_busy", {15'h0, cpu_busy}, 16'h0000);
    chk("reset_v", {3'b0, chr_addr}, 16'h0000);
    chk("idle_fetch_zero", {8'h00, VRAM_data_out}, 16'h0000);

    // PPUADDR loading and the write toggle
    addr_wr(8'h23); addr_wr(8'h25);
    chk("v_2325", {3'b0, chr_addr}, 16'h0325);
    chk("busy_idle", {15'h0, cpu_busy}, 16'h0000);
    chk("dout_idle", {8'h00, cpu_dout}, 16'h0000);
    addr_wr(8'h3F);
    addr_latch_clr = 1'b1; tick(); addr_latch_clr = 1'b0;
    addr_wr(8'h21); addr_wr(8'h00);
    chk("latch_clr_alone", {3'b0, chr_addr}, 16'h0100);
    addr_wr(8'h2A);
    addr_latch_clr = 1'b1; addr_wr(8'h21); addr_latch_clr = 1'b0;
    addr_wr(8'h40);
    chk("latch_clr_with_wr", {3'b0, chr_addr}, 16'h0140);

    // Nametable mirroring
    set_v(16'h2005); data_wr(8'hAB);
    set_v(16'h2805); data_wr(8'hCD);
    render_active = 1'b1;
    fetch_chk("horiz_2405", 16'h2405, 8'hAB);
    fetch_chk("horiz_2805", 16'h2805, 8'hCD);
    fetch_chk("horiz_2005", 16'h2005, 8'hAB);
    mirror_vert = 1'b1;
    fetch_chk("vert_2805", 16'h2805, 8'hAB);
    fetch_chk("vert_2C05", 16'h2C05, 8'hCD);
    fetch_chk("chr_fetch_hibits", 16'hD234, 8'h34 ^ 8'h5A);
    chk("chr_addr_fetch", {3'b0, chr_addr}, 16'h1234);
    mirror_vert = 1'b0;
    render_active = 1'b0;
    #1;
    chk("fetch_off_zero", {8'h00, VRAM_data_out}, 16'h0000);

    // Buffered PPUDATA reads
    set_v(16'h2000); data_wr(8'h11); data_wr(8'h22);
    set_v(16'h2F00); data_wr(8'h77);
    set_v(16'h2000);
    data_rd(8'h00); pop_chk("rd_buffer_first");
    data_rd(8'h11); pop_chk("rd_buffer_second");
    chk("v_after_reads", {3'b0, chr_addr}, 16'h0002);

    // Palette: direct read and mirror aliasing
    set_v(16'h3F10); data_wr(8'hFF);
    set_v(16'h3F00);
    data_rd(8'h3F); pop_chk("pal_rd_direct");
    set_v(16'h2000);
    data_rd(8'h77); pop_chk("rbuf_from_nt_2F00");
    render_active = 1'b1;
    fetch_chk("pal_alias_3F10", 16'h3F10, 8'h3F);
    fetch_chk("pal_3F04_reset", 16'h3F04, 8'h00);
    render_active = 1'b0;

    // Deferred write, second strobe dropped
    set_v(16'h2100); data_wr(8'h00); data_wr(8'h00);
    set_v(16'h2100);
    render_active = 1'b1;
    data_wr(8'h55);
    chk("busy_deferred", {15'h0, cpu_busy}, 16'h0001);
    fetch_chk("mem_unchanged", 16'h2100, 8'h00);
    data_wr(8'h66);
    chk("busy_held", {15'h0, cpu_busy}, 16'h0001);
    render_active = 1'b0;
    tick();
    chk("busy_cleared", {15'h0, cpu_busy}, 16'h0000);
    chk("v_after_commit", {3'b0, chr_addr}, 16'h0101);
    render_active = 1'b1;
    fetch_chk("deferred_data", 16'h2100, 8'h55);
    fetch_chk("dropped_not_written", 16'h2101, 8'h00);
    render_active = 1'b0;

    // Pending read commits while a new strobe is captured behind it
    set_v(16'h2000);
    render_active = 1'b1;
    data_rd(8'h11);
    chk("busy_rd_pending", {15'h0, cpu_busy}, 16'h0001);
    render_active = 1'b0;
    data_rd(8'h11);
    pop_chk("overlap_first");
    chk("busy_overlap", {15'h0, cpu_busy}, 16'h0001);
    tick();
    pop_chk("overlap_second");
    chk("busy_overlap_done", {15'h0, cpu_busy}, 16'h0000);
    data_rd(8'h22); pop_chk("after_overlap");
    chk("v_after_overlap", {3'b0, chr_addr}, 16'h0003);

    // Increment-by-32 wrap into CHR space
    set_v(16'h3FF0);
    addr_inc32 = 1'b1;
    data_wr(8'h12);
    chk("v_wrap", {3'b0, chr_addr}, 16'h0010);
    data_wr(8'h99);
    chk("v_inc32_chr", {3'b0, chr_addr}, 16'h0030);
    addr_inc32 = 1'b0;
    render_active = 1'b1;
    fetch_chk("chr_untouched", 16'h0010, 8'h10 ^ 8'h5A);
    fetch_chk("pal_3FF0_alias", 16'h3F00, 8'h12);

    // Reset while an op is pending
    data_wr(8'h42);
    chk("busy_before_reset", {15'h0, cpu_busy}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("busy_async_reset", {15'h0, cpu_busy}, 16'h0000);
    render_active = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("v_after_reset", {3'b0, chr_addr}, 16'h0000);
    chk("dout_after_reset", {8'h00, cpu_dout}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
